mem_swap_ctrl: RTL and testbench
================================

MEM_SWAP_CTRL -- requirements
Module: mem_swap_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, 8, number of memory words (address range 0..DEPTH-1).
REQ-002 SHALL have parameter DW, 26, memory data width.
REQ-003 SHALL have parameter MAW, 26, memory address port width; bits above 3 are driven 0.
REQ-004 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  in  1  command request.
REQ-007 SHALL have port req_ready  out  1  controller idle and accepting.
REQ-008 SHALL have port req_op  in  2  operation: 00 READ, 01 WRITE, 10 SWAP, 11 FILL.
REQ-009 SHALL have port req_addr_a  in  3  first word address.
REQ-010 SHALL have port req_addr_b  in  3  second word address (SWAP only).
REQ-011 SHALL have port req_data  in  DW  write/fill data.
REQ-012 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_data  out  DW  result word.
REQ-014 SHALL have port rsp_err  out  1  illegal-op flag, valid with rsp_valid.
REQ-015 SHALL have port mem_addr  out  MAW  memory address.
REQ-016 SHALL have port mem_we  out  1  memory write enable.
REQ-017 SHALL have port mem_in  out  DW  memory write data.
REQ-018 SHALL have port mem_out  in  DW  memory read data, combinational from mem_addr.

Function
REQ-019 SHALL implement FSM states IDLE, RD_A, RD_B, WR_A, WR_B, FILL, RESP.
REQ-020 SHALL assert req_ready only in IDLE; accept when req_valid&&req_ready, latching op, addr_a, addr_b, data.
REQ-021 SHALL transition on acceptance: READ->RD_A, WRITE->WR_A, SWAP->RD_A, FILL->FILL.
REQ-022 SHALL in RD_A drive mem_addr=addr_a, mem_we=0; at edge capture mem_out into tmp_a; READ->RESP, SWAP->RD_B.
REQ-023 SHALL in RD_B drive mem_addr=addr_b; capture mem_out into tmp_b; go WR_A.
REQ-024 SHALL in WR_A drive mem_addr=addr_a, mem_we=1, mem_in=data (WRITE) or tmp_b (SWAP); WRITE->RESP, SWAP->WR_B.
REQ-025 SHALL in WR_B drive mem_addr=addr_b, mem_we=1, mem_in=tmp_a; go RESP.
REQ-026 SHALL in FILL write data at fill counter address, counter 0..DEPTH-1 one per cycle; after DEPTH-1 go RESP.
REQ-027 SHALL in RESP pulse rsp_valid for exactly one cycle, then return to IDLE; no backpressure.
REQ-028 SHALL set rsp_data: READ tmp_a; WRITE/FILL data; SWAP tmp_a (old value at addr_a).
REQ-029 SHALL give busy cycles (accept to IDLE): READ 2, WRITE 2, SWAP 5, FILL DEPTH+1.
REQ-030 SHALL, for SWAP with addr_a==addr_b, execute all states and leave memory unchanged.
REQ-031 SHALL in IDLE/RESP drive mem_addr=0, mem_we=0, mem_in=0; mem_* are Moore decodes of state and latched registers.
REQ-032 SHALL ignore req_valid and all req_* inputs while not in IDLE.

Reset
REQ-033 SHALL on rst_n=0 at any edge, including mid-operation, enter IDLE; clear tmp_a, tmp_b, fill counter, rsp_data, rsp_err; rsp_valid=0, mem_we=0.
REQ-034 SHALL drive req_ready=1 in the first cycle after reset release.

Configuration
REQ-035 SHALL use macro MEM_SWAP_FILL_EN: defined -> FILL supported per REQ-026.
REQ-036 SHALL, without MEM_SWAP_FILL_EN, route op 11 IDLE->RESP with rsp_err=1, rsp_data=0, no memory write; no FILL state or counter logic.

Structure
REQ-037 SHALL place op encodings, state enum, DEPTH/DW defaults in shared package mem_ctrl_pkg.
REQ-038 SHALL be a single module with no sub-modules; the bench instantiates the existing 8x26 memory alongside.

Verification
REQ-039 Scenario: WRITE addr_a=3 data=0x155AAAA, then READ addr_a=3 -> rsp_data=0x155AAAA, rsp_err=0, each rsp_valid 2 cycles after accept.
REQ-040 Scenario: mem[1]=0x11, mem[6]=0x66; SWAP a=1 b=6 -> mem[1]=0x66, mem[6]=0x11, rsp_data=0x11, rsp_valid 5 cycles after accept.
REQ-041 Scenario: SWAP a=2 b=2 with mem[2]=0x2A -> mem[2]=0x2A, rsp_data=0x2A.
REQ-042 Scenario: FILL data=0x3FFFFFF with macro -> all 8 words 0x3FFFFFF, rsp_valid 9 cycles after accept; without macro -> rsp_err=1, memory unchanged, rsp_valid 1 cycle after accept.
REQ-043 Scenario: rst_n=0 during WR_A of SWAP -> next cycle IDLE, mem_we=0, req_ready=1 after release, no rsp_valid.
REQ-044 Scenario: req_valid held high with new op during busy SWAP -> only first op executes; second accepted on the cycle req_ready returns to 1.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and defaults for the memory swap controller:
//               command opcodes, FSM state encoding and parameter defaults.
//               Macro MEM_SWAP_FILL_EN adds the FILL state to the encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  // Parameter defaults for the 8 x 26 memory this controller fronts.
  localparam int DEPTH_DEF = 8;
  localparam int DW_DEF    = 26;
  localparam int MAW_DEF   = 26;

  // Width of the word-address fields carried on the request bus.
  localparam int AW = 3;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SWAP  = 2'b10,
    OP_FILL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    RESP = 3'd5
`ifdef MEM_SWAP_FILL_EN
    , FILL = 3'd6
`endif
  } state_e;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_swap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_swap_ctrl_if
// Description : Command/response handshake plus the memory-side bus of the
//               swap controller. The controller uses the slave modport; the
//               requester together with the memory uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_swap_ctrl_if #(
  parameter int DW  = 26,
  parameter int MAW = 26
) ();

  // Command channel
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [2:0]    req_addr_a;
  logic [2:0]    req_addr_b;
  logic [DW-1:0] req_data;

  // Response channel
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  // Memory port (read data is combinational from mem_addr)
  logic [MAW-1:0] mem_addr;
  logic           mem_we;
  logic [DW-1:0]  mem_in;
  logic [DW-1:0]  mem_out;

  modport slave (
    input  req_valid, req_op, req_addr_a, req_addr_b, req_data, mem_out,
    output req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_we, mem_in
  );

  modport master (
    output req_valid, req_op, req_addr_a, req_addr_b, req_data, mem_out,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_we, mem_in
  );

endinterface : mem_swap_ctrl_if
`default_nettype wire

// File: rtl/mem_swap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_swap_ctrl
// Description : Single-port memory command controller. Executes READ, WRITE,
//               SWAP (exchange two words) and FILL (write one value to every
//               word) one command at a time, with a one-cycle response pulse.
//               Macro MEM_SWAP_FILL_EN enables FILL; without it op 11 is
//               answered immediately with rsp_err=1 and no memory access.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_swap_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF,
  parameter int MAW   = MAW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_swap_ctrl_if.slave bus
);

  // Word addresses are AW bits wide, so the memory cannot exceed 2**AW words
  // and the memory address port must be able to carry a full word address.
  if (DEPTH < 1 || DEPTH > (1 << AW) || MAW < AW) begin : g_param_chk
    $error("mem_swap_ctrl: DEPTH must be 1..%0d and MAW >= %0d", 1 << AW, AW);
  end

`ifdef MEM_SWAP_FILL_EN
  localparam int FILL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);
`endif

  state_e        state_q;
  op_e           op_q;
  logic [AW-1:0] addr_a_q;
  logic [AW-1:0] addr_b_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] tmp_a_q;
  logic [DW-1:0] tmp_b_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_err_q;
`ifdef MEM_SWAP_FILL_EN
  logic [FILL_W-1:0] fill_cnt_q;
`endif

  logic [MAW-1:0] mem_addr_d;
  logic           mem_we_d;
  logic [DW-1:0]  mem_in_d;

  // Command FSM: latches the accepted request and walks the access sequence;
  // response outputs are loaded on the transition into RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      data_q      <= '0;
      tmp_a_q     <= '0;
      tmp_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef MEM_SWAP_FILL_EN
      fill_cnt_q  <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q     <= op_e'(bus.req_op);
            addr_a_q <= bus.req_addr_a;
            addr_b_q <= bus.req_addr_b;
            data_q   <= bus.req_data;
            unique case (op_e'(bus.req_op))
              OP_READ,
              OP_SWAP:  state_q <= RD_A;
              OP_WRITE: state_q <= WR_A;
              OP_FILL: begin
`ifdef MEM_SWAP_FILL_EN
                fill_cnt_q <= '0;
                state_q    <= FILL;
`else
                state_q     <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
`endif
              end
            endcase
          end
        end
        RD_A: begin
          tmp_a_q <= bus.mem_out;
          if (op_q == OP_SWAP) begin
            state_q <= RD_B;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.mem_out;
            rsp_err_q   <= 1'b0;
          end
        end
        RD_B: begin
          tmp_b_q <= bus.mem_out;
          state_q <= WR_A;
        end
        WR_A: begin
          if (op_q == OP_SWAP) begin
            state_q <= WR_B;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= data_q;
            rsp_err_q   <= 1'b0;
          end
        end
        WR_B: begin
          // Old word at addr_a is the SWAP result, even when addr_a == addr_b.
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= tmp_a_q;
          rsp_err_q   <= 1'b0;
        end
`ifdef MEM_SWAP_FILL_EN
        FILL: begin
          if (fill_cnt_q == FILL_LAST) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= data_q;
            rsp_err_q   <= 1'b0;
          end else begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
          end
        end
`endif
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port is a pure Moore decode of the state and latched operands.
  always_comb begin
    mem_addr_d = '0;
    mem_we_d   = 1'b0;
    mem_in_d   = '0;
    unique case (state_q)
      RD_A: mem_addr_d = MAW'(addr_a_q);
      RD_B: mem_addr_d = MAW'(addr_b_q);
      WR_A: begin
        mem_addr_d = MAW'(addr_a_q);
        mem_we_d   = 1'b1;
        mem_in_d   = (op_q == OP_SWAP) ? tmp_b_q : data_q;
      end
      WR_B: begin
        mem_addr_d = MAW'(addr_b_q);
        mem_we_d   = 1'b1;
        mem_in_d   = tmp_a_q;
      end
`ifdef MEM_SWAP_FILL_EN
      FILL: begin
        mem_addr_d = MAW'(fill_cnt_q);
        mem_we_d   = 1'b1;
        mem_in_d   = data_q;
      end
`endif
      default: ;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_we    = mem_we_d;
  assign bus.mem_in    = mem_in_d;

endmodule : mem_swap_ctrl
`default_nettype wire

// File: tb/tb_mem_swap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_swap_ctrl
// Description : Self-checking bench for mem_swap_ctrl with an 8 x 26 memory
//               attached and a word-array reference model of the commands.
//               Honours MEM_SWAP_FILL_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_swap_ctrl;
  import mem_ctrl_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 26;
  localparam int MAW   = 26;
`ifdef MEM_SWAP_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_swap_ctrl_if #(.DW(DW), .MAW(MAW)) bus ();

  mem_swap_ctrl #(.DEPTH(DEPTH), .DW(DW), .MAW(MAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // The 8 x 26 memory: combinational read, write on rising edge.
  logic [DW-1:0] mem [DEPTH];
  assign bus.mem_out = mem[bus.mem_addr[2:0]];
  always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_addr[2:0]] <= bus.mem_in;

  // Reference model state and counters.
  logic [DW-1:0] ref_mem [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  // Cycles from the accepting edge until the response is seen.
  function automatic int exp_lat(input logic [1:0] op);
    case (op)
      2'b00, 2'b01: return 2;
      2'b10:        return 5;
      default:      return FILL_EN ? DEPTH + 1 : 1;
    endcase
  endfunction

  // Command semantics on the word array; returns the expected response.
  task automatic model_op(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                          input logic [DW-1:0] d, output logic [DW-1:0] ed, output logic ee);
    logic [DW-1:0] t;
    ee = 1'b0;
    case (op)
      2'b00: ed = ref_mem[a];
      2'b01: begin ref_mem[a] = d; ed = d; end
      2'b10: begin t = ref_mem[a]; ref_mem[a] = ref_mem[b]; ref_mem[b] = t; ed = t; end
      default: begin
        if (FILL_EN) begin
          for (int k = 0; k < DEPTH; k++) ref_mem[k] = d;
          ed = d;
        end else begin
          ed = '0;
          ee = 1'b1;
        end
      end
    endcase
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
  endtask

  // Issues one command (called at a negedge); returns response and latency
  // (-1 when no response arrives within the bound).
  task automatic run_op(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd, output logic re,
                        output int lat);
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_addr_a = a;
    bus.req_addr_b = b;
    bus.req_data   = d;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'($urandom_range(0, 3));
    bus.req_addr_a = 3'($urandom_range(0, 7));
    bus.req_data   = DW'($urandom);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    rd = bus.rsp_data;
    re = bus.rsp_err;
    if (bus.rsp_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
    n_checks++; if (bus.rsp_data !== '0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got data %h err %b expected 0/0", bus.rsp_data, bus.rsp_err); end
    n_checks++; if (bus.mem_addr !== '0 || bus.mem_in !== '0) begin n_fail++; $display("FAIL reset_mem_bus: got addr %h in %h expected 0/0", bus.mem_addr, bus.mem_in); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_init();
    logic [DW-1:0] ed, rd; logic ee, re; int lat;
    for (int k = 0; k < DEPTH; k++) begin
      logic [DW-1:0] d = DW'($urandom);
      model_op(2'b01, 3'(k), 3'd0, d, ed, ee);
      run_op(2'b01, 3'(k), 3'd0, d, rd, re, lat);
    end
    @(negedge clk);
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++; if (mem[k] !== ref_mem[k]) begin n_fail++; $display("FAIL init_mem[%0d]: got %h expected %h", k, mem[k], ref_mem[k]); end
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] ed, rd; logic ee, re; int lat;
    model_op(2'b01, 3'd3, 3'd0, 26'h155AAAA, ed, ee);
    run_op(2'b01, 3'd3, 3'd0, 26'h155AAAA, rd, re, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL write_latency: got %0d expected 2", lat); end
    n_checks++; if (rd !== ed || re !== 1'b0) begin n_fail++; $display("FAIL write_rsp: got %h/%b expected %h/0", rd, re, ed); end
    model_op(2'b00, 3'd3, 3'd0, '0, ed, ee);
    run_op(2'b00, 3'd3, 3'd5, DW'($urandom), rd, re, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL read_latency: got %0d expected 2", lat); end
    n_checks++; if (rd !== 26'h155AAAA || re !== 1'b0) begin n_fail++; $display("FAIL read_rsp: got %h/%b expected 155aaaa/0", rd, re); end
  endtask

  // Cycle-by-cycle look at the memory bus during SWAP a=1 b=6.
  task automatic test_swap();
    logic [DW-1:0] ed, rd; logic ee, re; int lat;
    model_op(2'b01, 3'd1, 3'd0, 26'h11, ed, ee);
    run_op(2'b01, 3'd1, 3'd0, 26'h11, rd, re, lat);
    model_op(2'b01, 3'd6, 3'd0, 26'h66, ed, ee);
    run_op(2'b01, 3'd6, 3'd0, 26'h66, rd, re, lat);
    model_op(2'b10, 3'd1, 3'd6, '0, ed, ee);
    wait_ready();
    bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_addr_a = 3'd1; bus.req_addr_b = 3'd6;
    @(negedge clk); bus.req_valid = 1'b0;
    n_checks++; if (bus.mem_addr !== MAW'(1) || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL swap_rd_a: got addr %h we %b expected 1/0", bus.mem_addr, bus.mem_we); end
    @(negedge clk);
    n_checks++; if (bus.mem_addr !== MAW'(6) || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL swap_rd_b: got addr %h we %b expected 6/0", bus.mem_addr, bus.mem_we); end
    @(negedge clk);
    n_checks++; if (bus.mem_addr !== MAW'(1) || bus.mem_we !== 1'b1 || bus.mem_in !== 26'h66) begin n_fail++; $display("FAIL swap_wr_a: got addr %h we %b in %h expected 1/1/66", bus.mem_addr, bus.mem_we, bus.mem_in); end
    @(negedge clk);
    n_checks++; if (bus.mem_addr !== MAW'(6) || bus.mem_we !== 1'b1 || bus.mem_in !== 26'h11) begin n_fail++; $display("FAIL swap_wr_b: got addr %h we %b in %h expected 6/1/11", bus.mem_addr, bus.mem_we, bus.mem_in); end
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ed || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL swap_rsp: got valid %b data %h we %b expected 1/%h/0", bus.rsp_valid, bus.rsp_data, bus.mem_we, ed); end
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL swap_pulse: got valid %b ready %b expected 0/1", bus.rsp_valid, bus.req_ready); end
    n_checks++; if (mem[1] !== 26'h66 || mem[6] !== 26'h11) begin n_fail++; $display("FAIL swap_mem: got %h/%h expected 66/11", mem[1], mem[6]); end
  endtask

  task automatic test_swap_same();
    logic [DW-1:0] ed, rd; logic ee, re; int lat;
    model_op(2'b01, 3'd2, 3'd0, 26'h2A, ed, ee);
    run_op(2'b01, 3'd2, 3'd0, 26'h2A, rd, re, lat);
    model_op(2'b10, 3'd2, 3'd2, '0, ed, ee);
    run_op(2'b10, 3'd2, 3'd2, DW'($urandom), rd, re, lat);
    @(negedge clk);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL swap_same_latency: got %0d expected 5", lat); end
    n_checks++; if (rd !== 26'h2A || mem[2] !== 26'h2A) begin n_fail++; $display("FAIL swap_same: got rsp %h mem %h expected 2a/2a", rd, mem[2]); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] ed, rd; logic ee, re; int lat;
    model_op(2'b11, 3'd0, 3'd0, 26'h3FFFFFF, ed, ee);
    run_op(2'b11, 3'd0, 3'd0, 26'h3FFFFFF, rd, re, lat);
    n_checks++; if (lat !== exp_lat(2'b11)) begin n_fail++; $display("FAIL fill_latency: got %0d expected %0d", lat, exp_lat(2'b11)); end
    n_checks++; if (rd !== ed || re !== ee) begin n_fail++; $display("FAIL fill_rsp: got %h/%b expected %h/%b", rd, re, ed, ee); end
    @(negedge clk);
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++; if (mem[k] !== ref_mem[k]) begin n_fail++; $display("FAIL fill_mem[%0d]: got %h expected %h", k, mem[k], ref_mem[k]); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] ed, rd, d; logic ee, re; int lat, r; logic [1:0] op; logic [2:0] a, b;
    for (int i = 0; i < 40; i++) begin
      r  = int'($urandom_range(0, 9));
      op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = 3'($urandom_range(0, 7));
      b  = 3'($urandom_range(0, 7));
      d  = DW'($urandom);
      model_op(op, a, b, d, ed, ee);
      run_op(op, a, b, d, rd, re, lat);
      n_checks++; if (lat !== exp_lat(op)) begin n_fail++; $display("FAIL rand%0d_latency op %0d: got %0d expected %0d", i, op, lat, exp_lat(op)); end
      n_checks++; if (rd !== ed) begin n_fail++; $display("FAIL rand%0d_data op %0d: got %h expected %h", i, op, rd, ed); end
      n_checks++; if (re !== ee) begin n_fail++; $display("FAIL rand%0d_err op %0d: got %b expected %b", i, op, re, ee); end
    end
    @(negedge clk);
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++; if (mem[k] !== ref_mem[k]) begin n_fail++; $display("FAIL rand_mem[%0d]: got %h expected %h", k, mem[k], ref_mem[k]); end
    end
  endtask

  // Reset lands during WR_A of SWAP 4<->5: the in-flight write to word 4
  // completes on that edge, WR_B never happens.
  task automatic test_reset_mid();
    logic [DW-1:0] ed, rd; logic ee, re; int lat; bit quiet = 1'b1;
    model_op(2'b01, 3'd4, 3'd0, 26'h0444444, ed, ee);
    run_op(2'b01, 3'd4, 3'd0, 26'h0444444, rd, re, lat);
    model_op(2'b01, 3'd5, 3'd0, 26'h0555555, ed, ee);
    run_op(2'b01, 3'd5, 3'd0, 26'h0555555, rd, re, lat);
    wait_ready();
    bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_addr_a = 3'd4; bus.req_addr_b = 3'd5;
    @(negedge clk); bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== MAW'(4)) begin n_fail++; $display("FAIL mid_in_wr_a: got we %b addr %h expected 1/4", bus.mem_we, bus.mem_addr); end
    rst_n = 1'b0;
    ref_mem[4] = ref_mem[5];
    @(negedge clk);
    n_checks++; if (bus.mem_we !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0) begin n_fail++; $display("FAIL mid_reset: got we %b valid %b data %h expected 0/0/0", bus.mem_we, bus.rsp_valid, bus.rsp_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b expected 1", bus.req_ready); end
    for (int k = 0; k < 6; k++) begin
      if (bus.rsp_valid !== 1'b0 || bus.mem_we !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL mid_no_rsp: got activity %b expected 0", !quiet); end
    n_checks++; if (mem[4] !== ref_mem[4] || mem[5] !== ref_mem[5]) begin n_fail++; $display("FAIL mid_mem: got %h/%h expected %h/%h", mem[4], mem[5], ref_mem[4], ref_mem[5]); end
  endtask

  // req_valid stays high through a SWAP while the request fields change to a
  // READ; the READ must be taken only once req_ready returns.
  task automatic test_back_to_back();
    logic [DW-1:0] ed, er; logic ee; int lat; bit busy_ok = 1'b1;
    logic [2:0] a = 3'($urandom_range(0, 3));
    logic [2:0] b = 3'($urandom_range(4, 7));
    model_op(2'b10, a, b, '0, ed, ee);
    model_op(2'b00, b, 3'd0, '0, er, ee);
    wait_ready();
    bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_addr_a = a; bus.req_addr_b = b;
    bus.req_data = DW'($urandom);
    @(negedge clk);
    bus.req_op = 2'b00; bus.req_addr_a = b; bus.req_addr_b = a; bus.req_data = DW'($urandom);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      if (bus.req_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk); lat++;
    end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL b2b_swap_latency: got %0d expected 5", lat); end
    n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_ready: got ready seen %b expected 0", !busy_ok); end
    n_checks++; if (bus.rsp_data !== ed) begin n_fail++; $display("FAIL b2b_swap_data: got %h expected %h", bus.rsp_data, ed); end
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_return: got %b expected 1", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got valid %b ready %b expected 0/0", bus.rsp_valid, bus.req_ready); end
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== er) begin n_fail++; $display("FAIL b2b_read: got valid %b data %h expected 1/%h", bus.rsp_valid, bus.rsp_data, er); end
    @(negedge clk);
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++; if (mem[k] !== ref_mem[k]) begin n_fail++; $display("FAIL b2b_mem[%0d]: got %h expected %h", k, mem[k], ref_mem[k]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_addr_a = 3'd0;
    bus.req_addr_b = 3'd0;
    bus.req_data   = '0;
    test_reset();
    test_init();
    test_write_read();
    test_swap();
    test_swap_same();
    test_fill();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_swap_ctrl
`default_nettype wire
